// File: rtl/bp_pkg.sv
// Purpose: shared types and helpers for the branch predictor (index/tag split, counter constants).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bp_pkg;

  // Counter value after reset: strongly not-taken.
  localparam int unsigned CNT_RESET = 0;

  // Direction flags kept per table entry. Each entry is this pair plus the
  // tag, target and counter fields. Those fields have parameter-dependent
  // widths, so branch_predictor wraps this struct into its entry type.
  typedef struct packed {
    logic valid;
    logic jump;
  } bp_flags_t;

  // Saturation ceiling of a w-bit counter (all ones).
  function automatic int unsigned cnt_max(input int unsigned w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Weakly taken: MSB set, remaining bits clear.
  function automatic int unsigned cnt_weak_taken(input int unsigned w);
    return 32'(64'd1 << (w - 1));
  endfunction

  // Table index: word-address bits directly above the ignored byte offset.
  function automatic int unsigned bp_index(input logic [63:0] pc, input int unsigned idx_bits);
    return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
  endfunction

  // Tag: every PC bit above the index field.
  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Purpose: next-state logic for a saturating up/down direction counter.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller qualifies when the result is stored.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic [COUNTER_WIDTH-1:0] i_cnt,
  input  logic                     i_inc,
  input  logic                     i_dec,
  input  logic                     i_set_max,
  output logic [COUNTER_WIDTH-1:0] o_cnt
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(cnt_max(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] CNT_MIN = COUNTER_WIDTH'(CNT_RESET);

  // Set-max wins over inc/dec; inc and dec hold at their respective rails.
  always_comb begin
    o_cnt = i_cnt;
    if (i_set_max) begin
      o_cnt = CNT_MAX;
    end else if (i_inc && (i_cnt != CNT_MAX)) begin
      o_cnt = i_cnt + 1'b1;
    end else if (i_dec && (i_cnt != CNT_MIN)) begin
      o_cnt = i_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Purpose: direct-mapped BTB with saturating direction counters, mispredict detection and statistics.
// Latency: lookup, mispredict and redirect are combinational; table and counters update on the next clk edge.
// Backpressure: none; fetch stalls need no input, the caller drops update_en for flushed/bubbled slots.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ENTRIES       = 16,
  parameter int COUNTER_WIDTH = 2,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pcf,
  output logic                     predict_takenf,
  output logic [ADDRESS_WIDTH-1:0] predict_targetf,
  input  logic                     update_en,
  input  logic [ADDRESS_WIDTH-1:0] pce,
  input  logic                     is_jumpe,
  input  logic                     takene,
  input  logic [ADDRESS_WIDTH-1:0] pctargete,
  input  logic                     predicted_takene,
  input  logic [ADDRESS_WIDTH-1:0] predicted_targete,
  output logic                     mispredicte,
  output logic [ADDRESS_WIDTH-1:0] redirect_pce,
  output logic [STAT_WIDTH-1:0]    branch_count,
  output logic [STAT_WIDTH-1:0]    mispredict_count
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int          TAG_W = ADDRESS_WIDTH - int'(IDX) - 2;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX        = COUNTER_WIDTH'(cnt_max(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] CNT_WEAK_TAKEN = COUNTER_WIDTH'(cnt_weak_taken(COUNTER_WIDTH));

  // Reject geometries the index split and counter logic cannot represent.
  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of 2 and at least 2");
  end
  if (COUNTER_WIDTH < 1) begin : g_bad_counter
    $error("branch_predictor: COUNTER_WIDTH must be at least 1");
  end

  typedef struct packed {
    bp_flags_t                flags;
    logic [TAG_W-1:0]         tag;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [COUNTER_WIDTH-1:0] counter;
  } entry_t;

  entry_t r_table [ENTRIES];

  logic [STAT_WIDTH-1:0] r_branch_count;
  logic [STAT_WIDTH-1:0] r_mispredict_count;

  // Fetch-side lookup wires.
  logic [IDX-1:0]   w_fidx;
  logic [TAG_W-1:0] w_ftag;
  logic             w_fhit;

  // Execute-side update wires.
  logic [IDX-1:0]           w_eidx;
  logic [TAG_W-1:0]         w_etag;
  entry_t                   w_eentry;
  logic                     w_ehit;
  logic [COUNTER_WIDTH-1:0] w_cnt_next;
  entry_t                   w_wr_entry;
  logic                     w_wr_en;

  assign w_fidx = IDX'(bp_index(64'(pcf), IDX));
  assign w_ftag = TAG_W'(bp_tag(64'(pcf), IDX));
  assign w_fhit = r_table[w_fidx].flags.valid && (r_table[w_fidx].tag == w_ftag);

  // Jumps are always taken once seen; branches follow the counter MSB.
  assign predict_takenf  = w_fhit &&
                           (r_table[w_fidx].flags.jump || r_table[w_fidx].counter[COUNTER_WIDTH-1]);
  assign predict_targetf = predict_takenf ? r_table[w_fidx].target
                                          : pcf + ADDRESS_WIDTH'(4);

  assign w_eidx   = IDX'(bp_index(64'(pce), IDX));
  assign w_etag   = TAG_W'(bp_tag(64'(pce), IDX));
  assign w_eentry = r_table[w_eidx];
  assign w_ehit   = w_eentry.flags.valid && (w_eentry.tag == w_etag);

  // A jump pins the counter high; a branch moves it one step toward its outcome.
  bp_sat_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_sat_counter (
    .i_cnt    (w_eentry.counter),
    .i_inc    (takene && !is_jumpe),
    .i_dec    (!takene && !is_jumpe),
    .i_set_max(is_jumpe),
    .o_cnt    (w_cnt_next)
  );

  // Build the replacement entry: train on hit, allocate only on a taken miss.
  always_comb begin
    w_wr_entry = w_eentry;
    w_wr_en    = 1'b0;
    if (update_en) begin
      if (w_ehit) begin
        w_wr_en            = 1'b1;
        w_wr_entry.counter = w_cnt_next;
        // jalr targets can move, so jumps refresh the target on every hit.
        if (takene || is_jumpe) begin
          w_wr_entry.target = pctargete;
        end
      end else if (takene) begin
        w_wr_en                = 1'b1;
        w_wr_entry.flags.valid = 1'b1;
        w_wr_entry.flags.jump  = is_jumpe;
        w_wr_entry.tag         = w_etag;
        w_wr_entry.target      = pctargete;
        w_wr_entry.counter     = is_jumpe ? CNT_MAX : CNT_WEAK_TAKEN;
      end
    end
  end

  // Table storage: whole-table clear on reset, else one entry written per resolved op.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_table[w_eidx] <= w_wr_entry;
    end
  end

  assign mispredicte  = update_en &&
                        ((predicted_takene != takene) ||
                         (takene && (predicted_targete != pctargete)));
  assign redirect_pce = takene ? pctargete : pce + ADDRESS_WIDTH'(4);

  // Event counters: free-running and wrapping, visible one cycle after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (update_en) begin
        r_branch_count <= r_branch_count + 1'b1;
      end
      if (mispredicte) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic against an array-based model.
module tb_branch_predictor;

  localparam int AW = 32;
  localparam int N  = 16;
  localparam int CW = 2;
  localparam int SW = 32;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] pcf;
  logic          predict_takenf;
  logic [AW-1:0] predict_targetf;
  logic          update_en;
  logic [AW-1:0] pce;
  logic          is_jumpe;
  logic          takene;
  logic [AW-1:0] pctargete;
  logic          predicted_takene;
  logic [AW-1:0] predicted_targete;
  logic          mispredicte;
  logic [AW-1:0] redirect_pce;
  logic [SW-1:0] branch_count;
  logic [SW-1:0] mispredict_count;

  branch_predictor #(
    .ADDRESS_WIDTH(AW),
    .ENTRIES      (N),
    .COUNTER_WIDTH(CW),
    .STAT_WIDTH   (SW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pcf              (pcf),
    .predict_takenf   (predict_takenf),
    .predict_targetf  (predict_targetf),
    .update_en        (update_en),
    .pce              (pce),
    .is_jumpe         (is_jumpe),
    .takene           (takene),
    .pctargete        (pctargete),
    .predicted_takene (predicted_takene),
    .predicted_targete(predicted_targete),
    .mispredicte      (mispredicte),
    .redirect_pce     (redirect_pce),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one slot per index, fields kept as plain values.
  bit          m_valid  [N];
  bit          m_jump   [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  int          m_cnt    [N];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i]  = 1'b0;
      m_jump[i]   = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_cnt[i]    = 0;
    end
    m_bc = '0;
    m_mc = '0;
  endtask

  task automatic m_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int  i;
    bit  hit;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_jump[i] || (m_cnt[i] >= 2));
    tg  = tk ? m_target[i] : pc + 32'd4;
  endtask

  task automatic m_train(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    if (m_valid[i] && (m_tag[i] == m_tagof(pc))) begin
      if (j) begin
        m_cnt[i]    = CMAX;
        m_target[i] = tgt;
      end else if (t) begin
        m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        m_target[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (t) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = m_tagof(pc);
      m_target[i] = tgt;
      m_jump[i]   = j;
      m_cnt[i]    = j ? CMAX : 2;
    end
  endtask

  // Apply one cycle of inputs and let combinational outputs settle.
  task automatic drive(input logic r, input logic u, input logic [31:0] fpc, input logic [31:0] epc,
                       input logic j, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    rst               = r;
    update_en         = u;
    pcf               = fpc;
    pce               = epc;
    is_jumpe          = j;
    takene            = t;
    pctargete         = tgt;
    predicted_takene  = pt;
    predicted_targete = ptgt;
    #3;
  endtask

  // Compare all outputs with the model, clock once, then advance the model.
  task automatic tick();
    logic        tk;
    logic [31:0] tg;
    logic        mp;
    m_predict(pcf, tk, tg);
    mp = update_en && ((predicted_takene != takene) || (takene && (predicted_targete != pctargete)));
    check("predict_takenf",   32'(predict_takenf), 32'(tk));
    check("predict_targetf",  predict_targetf, tg);
    check("mispredicte",      32'(mispredicte), 32'(mp));
    check("redirect_pce",     redirect_pce, takene ? pctargete : pce + 32'd4);
    check("branch_count",     branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
    @(posedge clk);
    #1;
    if (rst) begin
      m_reset();
    end else if (update_en) begin
      m_bc = m_bc + 32'd1;
      if (mp) m_mc = m_mc + 32'd1;
      m_train(pce, is_jumpe, takene, pctargete);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) p = p | 32'hFFFF_FF00;
    return p;
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 3))
      0:       return 32'h80;
      1:       return 32'h90;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    // Cold lookup.
    drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("cold_taken", 32'(predict_takenf), 32'd0);
    check("cold_target", predict_targetf, 32'h104);
    tick();

    // Allocate taken branch 0x100 -> 0x80.
    drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("alloc_taken", 32'(predict_takenf), 32'd1);
    check("alloc_target", predict_targetf, 32'h80);
    tick();

    // Train down twice, then a not-taken miss at 0x200.
    drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    check("down1_target", predict_targetf, 32'h104);
    tick();
    drive(1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'h44, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("nt_miss_target", predict_targetf, 32'h204);
    tick();

    // Alias replace: 0x140 shares index 0 with 0x100.
    drive(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h140, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("alias_target", predict_targetf, 32'h200);
    tick();
    drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("alias_old_miss", predict_targetf, 32'h104);
    tick();

    // Wrong target on a taken branch.
    drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80);
    check("misp_flag", 32'(mispredicte), 32'd1);
    check("misp_redirect", redirect_pce, 32'h90);
    tick();
    // Correctly predicted not-taken.
    drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("ok_flag", 32'(mispredicte), 32'd0);
    check("ok_redirect", redirect_pce, 32'h104);
    tick();

    // Same-cycle lookup and jump update at one index: lookup sees old entry.
    drive(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
    check("bypass_old", predict_targetf, 32'h104);
    tick();
    drive(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("jump_target", predict_targetf, 32'h44);
    tick();

    // Reset wins over a coincident update.
    drive(1'b1, 1'b1, 32'h100, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_miss", predict_targetf, 32'h304);
    check("rst_bc", branch_count, 32'd0);
    check("rst_mc", mispredict_count, 32'd0);
    tick();

    // Random traffic over a small PC set to force hits, aliases and wraps.
    for (int k = 0; k < 800; k++) begin
      logic [31:0] fp;
      logic [31:0] ep;
      logic [31:0] tg;
      logic [31:0] ptg;
      logic        r;
      logic        u;
      logic        j;
      logic        t;
      logic        pt;
      fp = rand_pc();
      ep = rand_pc();
      r  = ($urandom_range(0, 99) == 0);
      u  = ($urandom_range(0, 3) != 0);
      j  = ($urandom_range(0, 5) == 0);
      t  = j ? 1'b1 : 1'($urandom_range(0, 1));
      tg = rand_tgt();
      if ($urandom_range(0, 1) == 0) begin
        m_predict(ep, pt, ptg);
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = rand_tgt();
      end
      drive(r, u, fp, ep, j, t, tg, pt, ptg);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage pipeline.
- Fetch-side lookup is combinational on the fetch-stage PC. It supplies the predicted next PC, which replaces the unconditional PC+4.
- The execute stage reports each resolved branch or jump. The block updates its table, flags a mispredict and supplies the redirect PC that drives the flush/PC-select logic.
- Keeps 32-bit event counters for branch and mispredict statistics.

Parameters:
ADDRESS_WIDTH, 32, PC width in bits
ENTRIES, 16, number of table entries; power of 2, minimum 2
COUNTER_WIDTH, 2, width of the saturating direction counter; minimum 1
STAT_WIDTH, 32, width of the statistics counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pcf  input  ADDRESS_WIDTH  fetch-stage PC
predict_takenf  output  1  fetch prediction: taken
predict_targetf  output  ADDRESS_WIDTH  predicted next PC
update_en  input  1  resolved branch/jump in execute, already qualified by the caller with not-flushed
pce  input  ADDRESS_WIDTH  execute-stage PC
is_jumpe  input  1  resolved op is jal/jalr
takene  input  1  actual outcome
pctargete  input  ADDRESS_WIDTH  actual target
predicted_takene  input  1  prediction carried down the pipeline for this op
predicted_targete  input  ADDRESS_WIDTH  predicted target carried down the pipeline
mispredicte  output  1  prediction was wrong
redirect_pce  output  ADDRESS_WIDTH  correct next PC after a mispredict
branch_count  output  STAT_WIDTH  number of resolved updates
mispredict_count  output  STAT_WIDTH  number of mispredicts

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset effect: every entry valid=0, counter=0, jump flag=0, tag/target=0. branch_count=0, mispredict_count=0. All clear in the single reset cycle.
- Reset priority: rst has priority over a coincident update_en. Reset mid-operation simply discards the pending update.
- Index and tag: index = PC[IDX+1:2] with IDX=log2(ENTRIES). Tag = PC[ADDRESS_WIDTH-1:IDX+2]. PC bits [1:0] are ignored.
- Lookup (combinational, zero latency): hit = valid[idx] && tag[idx]==tag(pcf).
- predict_takenf = hit && (jump[idx] || counter[idx] MSB).
- predict_targetf = target[idx] when predict_takenf, else pcf+4. Addition wraps modulo 2^ADDRESS_WIDTH.
- Update on posedge when update_en && !rst, using the entry indexed by pce:
  - Hit, conditional branch: counter +1 if takene, -1 if not. Saturate at 2^COUNTER_WIDTH-1 and at 0. Target is written with pctargete when takene.
  - Hit, jump: counter set to its maximum; target written with pctargete every time (jalr target may change).
  - Miss, takene=1: allocate and overwrite the aliased entry. valid=1, tag=tag(pce), target=pctargete, jump=is_jumpe. Counter = weakly taken (1 followed by zeros), or maximum for a jump.
  - Miss, takene=0: no allocation, table unchanged.
- Same-index lookup and update in one cycle: the lookup sees pre-update contents. There is no bypass.
- Mispredict (combinational): mispredicte = update_en && ((predicted_takene != takene) || (takene && predicted_targete != pctargete)).
- Redirect (combinational): redirect_pce = takene ? pctargete : pce+4.
- Statistics: branch_count increments on every update_en. mispredict_count increments when mispredicte=1. Both wrap modulo 2^STAT_WIDTH with no saturation. Both are registered, so a new value is visible the cycle after the event.
- Stalls: lookup is pure combinational, so fetch stall needs no input. The caller must not assert update_en for a flushed or bubbled execute slot.
- Invalid parameters: ENTRIES not a power of 2, or COUNTER_WIDTH=0, triggers an elaboration-time error.

Decomposition:
- Shared package bp_pkg holds:
  - the entry struct typedef (valid, jump, tag, target, counter);
  - functions for the index/tag split;
  - counter constants CNT_MAX, CNT_WEAK_TAKEN, CNT_RESET.
- One natural sub-module: bp_sat_counter. It takes current value, inc/dec/set-max controls and COUNTER_WIDTH, and returns the next saturated value. It is instantiated once in the update path.
- Table storage lives in flops inside branch_predictor. ENTRIES is small, so single-cycle reset clear is required.

Test Plan (ENTRIES=16, COUNTER_WIDTH=2):
- Cold lookup: after reset, pcf=0x100 -> predict_takenf=0, predict_targetf=0x104.
- Allocate: update pce=0x100, takene=1, pctargete=0x80, is_jumpe=0 -> next cycle pcf=0x100 gives predict_takenf=1, predict_targetf=0x80 (counter 2).
- Train down: two not-taken updates at 0x100 -> after the first, counter 1, predict_takenf=0, predict_targetf=0x104; after the second, counter stays saturated at 0. A not-taken miss at 0x200 leaves the table unchanged.
- Alias replace: taken update pce=0x140 (same index as 0x100), target 0x200 -> pcf=0x140 predicts 0x200; pcf=0x100 misses and gives 0x104.
- Mispredict and stats: predicted_takene=1, predicted_targete=0x80, takene=1, pctargete=0x90, update_en=1 -> mispredicte=1, redirect_pce=0x90; next cycle branch_count and mispredict_count are each +1. Correct not-taken case (predicted_takene=0, takene=0, pce=0x100) -> mispredicte=0, redirect_pce=0x104.
- Reset priority: rst=1 together with update_en=1 at 0x300 -> next cycle all lookups miss and both counts are 0. Same-cycle lookup/update at one index -> lookup returns old contents.
